lsu_mem_port: RTL and testbench
===============================

Name: lsu_mem_port

Overview:
Load/store initiator between the pipeline MEM stage and the word-addressed data RAM. It accepts one byte/halfword/word request at a time and checks alignment and range. It turns byte addresses into RAM word indices, performs sub-word stores as read-modify-write, and returns sign- or zero-extended load data with a valid/ready response handshake.

Parameters:
MEM_WORDS, 256, RAM depth in 32-bit words; power of two; byte range is 0 .. 4*MEM_WORDS-1.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request.
req_we  input  1  1 = store, 0 = load.
req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
req_addr  input  32  byte address.
req_wdata  input  32  store data, right-aligned.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer takes response.
rsp_rdata  output  32  extended load data; 0 for stores and errors.
rsp_err  output  1  misaligned, out-of-range or reserved size.
mem_we  output  1  RAM write enable.
mem_addr  output  32  RAM word index.
mem_wdata  output  32  RAM write data.
mem_rdata  input  32  RAM read data; combinational from mem_addr.

Behaviour:
- States: IDLE, ACCESS, WRITE, RESP. req_ready = (state == IDLE).
- Reset: state to IDLE; rsp_valid, rsp_err, rsp_rdata and all captured registers to 0.
- mem_we is forced to 0 whenever reset is high, including mid-operation, so no write commits during reset.
- Accept: in IDLE, when req_valid is high, capture all request fields.
- Error check at accept:
  - Error if req_size = 11.
  - Error if halfword and addr[0] = 1.
  - Error if word and addr[1:0] != 00.
  - Error if addr >= 4*MEM_WORDS.
  - On error: go to RESP with rsp_err = 1 and rsp_rdata = 0. No RAM access occurs.
- Otherwise go to ACCESS. mem_addr = {2'b00, addr[31:2]} in ACCESS and WRITE; 0 in IDLE and RESP.
- ACCESS, load: extract the lane selected by addr[1:0] (little-endian; byte k = bits 8k+7:8k; halfword at addr[1]). Extend per req_unsigned, register into rsp_rdata, go to RESP.
- ACCESS, word store: mem_we = 1, mem_wdata = req_wdata, go to RESP.
- ACCESS, sub-word store: latch mem_rdata as the old word, mem_we = 0, go to WRITE.
- WRITE: mem_we = 1. mem_wdata = old word with the target lane replaced by req_wdata[7:0] or req_wdata[15:0]; other bytes unchanged. Go to RESP.
- mem_we is high only in ACCESS (word store) or WRITE, for exactly one cycle per store. mem_wdata = 0 when mem_we = 0.
- RESP: rsp_valid = 1. rsp_rdata and rsp_err are held stable until rsp_ready. On rsp_valid && rsp_ready go to IDLE.
- No same-cycle turnaround: a new request is accepted at the earliest one cycle after the response handshake.
- Latency, accept edge to first rsp_valid cycle:
  - Error: 1 cycle.
  - Load or word store: 2 cycles.
  - Sub-word store: 3 cycles.
- rsp_ready held low: the block stalls in RESP indefinitely; req_ready stays low.
- req_valid is ignored outside IDLE.

Test Plan:
- After reset, check reset values. Word store addr 0x10, data 0xDEADBEEF -> one mem_we pulse with mem_addr 4, mem_wdata 0xDEADBEEF; rsp_valid 2 cycles after accept; rsp_err 0.
- Loads from word 4 = 0xDEADBEEF:
  - Signed byte load addr 0x13 -> rsp_rdata 0xFFFFFFDE.
  - Unsigned halfword load addr 0x12 -> 0x0000DEAD.
  - Word load addr 0x10 -> 0xDEADBEEF.
- Byte store 0x55 at 0x11 -> cycle 1 read (mem_we 0), cycle 2 mem_we 1 with mem_wdata 0xDEAD55EF, rsp 3 cycles after accept. A following word load of 0x10 returns 0xDEAD55EF.
- Errors, each giving rsp_err 1 one cycle after accept, no mem_we, rsp_rdata 0:
  - Halfword at 0x11.
  - Word at 0x12.
  - Word at 0x400 (MEM_WORDS = 256).
  - req_size 11.
- Response backpressure: hold rsp_ready low 5 cycles -> rsp_valid and rsp_rdata stable, req_ready 0. Release -> IDLE next cycle; a request presented in the handshake cycle is not accepted until the following cycle.
- Assert reset during the ACCESS cycle of a sub-word store -> no mem_we pulse; IDLE and all outputs 0 after the edge; RAM word unchanged.

Source files
------------

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store initiator between the MEM stage and a word-addressed
// data RAM. Takes one byte/halfword/word request at a time and checks size,
// alignment and range. Sub-word stores are done as read-modify-write.
// Load data is returned sign- or zero-extended through a valid/ready response.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   req_*           request channel (valid/ready, we, size, unsigned, addr, wdata)
//   rsp_*           response channel (valid/ready, rdata, err)
//   mem_*           RAM side: word index, write enable/data, combinational read data
module lsu_mem_port #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] BYTE_LIMIT = 32'(4 * MEM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE, S_RESP} state_t;

  state_t      r_state, w_next;

  // Captured request and response registers
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_old;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_err;
  logic        w_accept;
  logic        w_word_st;
  logic        w_we;
  logic [4:0]  w_lane_sh;
  logic [15:0] w_lane;
  logic [31:0] w_load;
  logic [31:0] w_mask;
  logic [31:0] w_merged;

  // Request checks are evaluated on the live inputs so the decision is made
  // in the accept cycle itself.
  assign w_err = (req_size == 2'b11) ||
                 (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && (req_addr[1:0] != 2'b00)) ||
                 (req_addr >= BYTE_LIMIT);

  assign w_accept  = (r_state == S_IDLE) && req_valid;
  assign w_word_st = (r_state == S_ACCESS) && r_we && (r_size == 2'b10);
  assign w_lane_sh = {r_addr[1:0], 3'b000};

  // Lane extraction: an aligned halfword has addr[0]=0, so the byte shift
  // serves both sizes.
  assign w_lane = 16'(mem_rdata >> w_lane_sh);

  always_comb begin
    w_load = mem_rdata;
    case (r_size)
      2'b00:   w_load = r_uns ? {24'b0, w_lane[7:0]}  : {{24{w_lane[7]}},  w_lane[7:0]};
      2'b01:   w_load = r_uns ? {16'b0, w_lane[15:0]} : {{16{w_lane[15]}}, w_lane[15:0]};
      default: w_load = mem_rdata;
    endcase
  end

  // Read-modify-write merge: replace only the target lane of the old word.
  assign w_mask   = ((r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << w_lane_sh;
  assign w_merged = (r_old & ~w_mask) | ((r_wdata << w_lane_sh) & w_mask);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_next = w_err ? S_RESP : S_ACCESS;
      S_ACCESS: w_next = (r_we && r_size != 2'b10) ? S_WRITE : S_RESP;
      S_WRITE:  w_next = S_RESP;
      S_RESP:   if (rsp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Output logic. The write strobe is gated by reset so nothing commits
  // during a reset that lands mid-operation.
  always_comb begin
    req_ready = (r_state == S_IDLE);
    rsp_valid = (r_state == S_RESP);
    w_we      = (w_word_st || r_state == S_WRITE) && !reset;
    mem_we    = w_we;
    mem_addr  = 32'b0;
    mem_wdata = 32'b0;
    if (r_state == S_ACCESS || r_state == S_WRITE)
      mem_addr = {2'b00, r_addr[31:2]};
    if (w_we)
      mem_wdata = w_word_st ? r_wdata : w_merged;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_addr  <= 32'b0;
      r_wdata <= 32'b0;
      r_old   <= 32'b0;
      r_rdata <= 32'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_size  <= req_size;
        r_uns   <= req_unsigned;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_err   <= w_err;
        r_rdata <= 32'b0;
      end
      if (r_state == S_ACCESS) begin
        if (!r_we)                  r_rdata <= w_load;
        else if (r_size != 2'b10)   r_old   <= mem_rdata;
      end
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Testbench for lsu_mem_port: directed test-plan scenarios plus randomized
// requests checked against a byte-array reference model.
module tb_lsu_mem_port;
  localparam int MW = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;
  int we_total = 0;

  logic        ram_init;
  logic [31:0] ram [0:MW-1];
  logic [7:0]  ref_bytes [0:4*MW-1];

  always #5 clk = ~clk;

  lsu_mem_port #(.MEM_WORDS(MW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'(i) * 32'h9E37_79B9 ^ 32'h5A5A_1234;
  endfunction

  // RAM model: combinational read, registered write
  assign mem_rdata = (mem_addr < MW) ? ram[mem_addr[7:0]] : 32'hBADC_0DE5;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < MW; i++) ram[i] <= init_word(i);
    end else if (mem_we && mem_addr < MW) begin
      ram[mem_addr[7:0]] <= mem_wdata;
    end
    if (mem_we) we_total++;
  end

  // Reference model over a byte array: computes response, latency, write
  // count and (for stores) the full RAM word that must be written.
  task automatic ref_access(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rd, output logic er, output int lat,
                            output int nwe, output logic [31:0] word);
    int nb;
    logic [31:0] base;
    nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    er   = (size == 2'd3) || ((addr % 32'(nb)) != 0) || (addr >= 32'(4 * MW));
    rd   = 32'b0;
    word = 32'b0;
    lat  = 1;
    nwe  = 0;
    if (!er) begin
      if (!we) begin
        lat = 2;
        for (int i = 0; i < nb; i++) rd = rd | (32'(ref_bytes[addr + 32'(i)]) << (8 * i));
        if (!uns && nb < 4 && rd[8 * nb - 1]) rd = rd | (32'hFFFF_FFFF << (8 * nb));
      end else begin
        for (int i = 0; i < nb; i++) ref_bytes[addr + 32'(i)] = wdata[8 * i +: 8];
        nwe  = 1;
        lat  = (nb == 4) ? 2 : 3;
        base = addr & ~32'd3;
        for (int i = 0; i < 4; i++) word = word | (32'(ref_bytes[base + 32'(i)]) << (8 * i));
      end
    end
  endtask

  // Drives one request and observes the DUT; no comparisons here.
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic er, output int lat,
                         output int nwe, output logic [31:0] wa, output logic [31:0] wd,
                         output logic tmo);
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk);
    rd = 32'b0; er = 1'bx; lat = 0; nwe = 0; wa = 32'b0; wd = 32'b0; tmo = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_we) begin nwe++; wa = mem_addr; wd = mem_wdata; end
      if (rsp_valid) begin lat = c; rd = rsp_rdata; er = rsp_err; tmo = 1'b0; break; end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid, rsp_err, mem_we} !== 4'b1000 || rsp_rdata !== 32'b0 ||
        mem_addr !== 32'b0 || mem_wdata !== 32'b0)
      $display("FAIL reset_state: rdy=%b vld=%b err=%b we=%b rd=%h ma=%h wd=%h, need 1 0 0 0 0 0 0",
               req_ready, rsp_valid, rsp_err, mem_we, rsp_rdata, mem_addr, mem_wdata);
    else n_pass++;
  endtask

  task automatic test_word_store;
    logic [31:0] rd, wa, wd, ew; logic er, tmo, eer; int lat, nwe, el, en;
    ref_access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, eer, el, en, ew);
    run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, er, lat, nwe, wa, wd, tmo);
    n_checks++;
    if (tmo || er !== 1'b0 || lat != 2 || rd !== 32'b0)
      $display("FAIL word_store_rsp: tmo=%b err=%b lat=%0d rd=%h, need 0 0 2 0", tmo, er, lat, rd);
    else n_pass++;
    n_checks++;
    if (nwe != 1 || wa !== 32'd4 || wd !== 32'hDEAD_BEEF)
      $display("FAIL word_store_mem: we_cnt=%0d addr=%h data=%h, need 1 4 deadbeef", nwe, wa, wd);
    else n_pass++;
  endtask

  task automatic test_loads;
    logic [1:0]  sz  [3] = '{2'd0, 2'd1, 2'd2};
    logic        un  [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] ad  [3] = '{32'h13, 32'h12, 32'h10};
    logic [31:0] exp [3] = '{32'hFFFF_FFDE, 32'h0000_DEAD, 32'hDEAD_BEEF};
    logic [31:0] rd, wa, wd; logic er, tmo; int lat, nwe;
    for (int k = 0; k < 3; k++) begin
      run_req(1'b0, sz[k], un[k], ad[k], 32'hFFFF_FFFF, rd, er, lat, nwe, wa, wd, tmo);
      n_checks++;
      if (tmo || er !== 1'b0 || lat != 2 || nwe != 0 || rd !== exp[k])
        $display("FAIL load_%0d: tmo=%b err=%b lat=%0d we_cnt=%0d rd=%h, need 0 0 2 0 %h",
                 k, tmo, er, lat, nwe, rd, exp[k]);
      else n_pass++;
    end
  endtask

  task automatic test_subword_store;
    logic [31:0] rd, wa, wd, ew; logic er, tmo, eer; int lat, nwe, el, en;
    ref_access(1'b1, 2'd0, 1'b0, 32'h11, 32'hAAAA_AA55, rd, eer, el, en, ew);
    run_req(1'b1, 2'd0, 1'b0, 32'h11, 32'hAAAA_AA55, rd, er, lat, nwe, wa, wd, tmo);
    n_checks++;
    if (tmo || er !== 1'b0 || lat != 3 || nwe != 1 || wa !== 32'd4 || wd !== 32'hDEAD_55EF)
      $display("FAIL byte_store: tmo=%b err=%b lat=%0d we_cnt=%0d addr=%h data=%h, need 0 0 3 1 4 dead55ef",
               tmo, er, lat, nwe, wa, wd);
    else n_pass++;
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, nwe, wa, wd, tmo);
    n_checks++;
    if (tmo || er !== 1'b0 || rd !== 32'hDEAD_55EF)
      $display("FAIL byte_store_readback: tmo=%b err=%b rd=%h, need 0 0 dead55ef", tmo, er, rd);
    else n_pass++;
  endtask

  task automatic test_errors;
    logic        we [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0]  sz [4] = '{2'd1, 2'd2, 2'd2, 2'd3};
    logic [31:0] ad [4] = '{32'h11, 32'h12, 32'h400, 32'h10};
    logic [31:0] rd, wa, wd; logic er, tmo; int lat, nwe;
    for (int k = 0; k < 4; k++) begin
      run_req(we[k], sz[k], 1'b0, ad[k], 32'h1234_5678, rd, er, lat, nwe, wa, wd, tmo);
      n_checks++;
      if (tmo || er !== 1'b1 || lat != 1 || nwe != 0 || rd !== 32'b0)
        $display("FAIL error_%0d: tmo=%b err=%b lat=%0d we_cnt=%0d rd=%h, need 0 1 1 0 0",
                 k, tmo, er, lat, nwe, rd);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] e1, e2, ew; logic eer, ok; int el, en;
    ref_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e1, eer, el, en, ew);
    ref_access(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, e2, eer, el, en, ew);
    @(negedge clk);
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk) req_valid = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== e1 || rsp_err !== 1'b0 || req_ready !== 1'b0) ok = 1'b0;
    end
    n_checks++;
    if (!ok) $display("FAIL bp_hold: vld=%b rd=%h rdy=%b, need 1 %h 0", rsp_valid, rsp_rdata, req_ready, e1);
    else n_pass++;
    // Handshake and a new request presented in the same cycle
    rsp_ready = 1'b1;
    req_size = 2'd0; req_addr = 32'h13; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL bp_no_turnaround: rdy=%b vld=%b, need 1 0", req_ready, rsp_valid);
    else n_pass++;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if (req_ready !== 1'b0 || mem_addr !== 32'd4)
      $display("FAIL bp_next_accept: rdy=%b ma=%h, need 0 4", req_ready, mem_addr);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== e2)
      $display("FAIL bp_next_rsp: vld=%b rd=%h, need 1 %h", rsp_valid, rsp_rdata, e2);
    else n_pass++;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd, wa, wd, ew, eword; logic er, tmo, eer; int lat, nwe, el, en, we0;
    ref_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, eword, eer, el, en, ew);
    we0 = we_total;
    // Reset during the read cycle of a byte store
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h11;
    req_wdata = 32'h77; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid, rsp_err, mem_we} !== 4'b1000 || rsp_rdata !== 32'b0 ||
        mem_addr !== 32'b0 || mem_wdata !== 32'b0)
      $display("FAIL reset_mid_state: rdy=%b vld=%b err=%b we=%b rd=%h ma=%h wd=%h, need 1 0 0 0 0 0 0",
               req_ready, rsp_valid, rsp_err, mem_we, rsp_rdata, mem_addr, mem_wdata);
    else n_pass++;
    reset = 1'b0;
    // Reset during the write cycle of a halfword store
    @(negedge clk);
    req_size = 2'd1; req_addr = 32'h12; req_wdata = 32'h1234; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk) req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (mem_we !== 1'b0) $display("FAIL reset_gates_we: we=%b, need 0", mem_we);
    else n_pass++;
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    n_checks++;
    if (we_total != we0) $display("FAIL reset_no_write: writes=%0d, need 0", we_total - we0);
    else n_pass++;
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, nwe, wa, wd, tmo);
    n_checks++;
    if (tmo || er !== 1'b0 || rd !== eword)
      $display("FAIL reset_ram_unchanged: tmo=%b err=%b rd=%h, need 0 0 %h", tmo, er, rd, eword);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [31:0] addr, wdata, rd, wa, wd, erd, ew; logic we, uns, er, tmo, eer;
    logic [1:0] size; int lat, nwe, el, en, r;
    for (int it = 0; it < 150; it++) begin
      r     = $urandom_range(0, 9);
      addr  = (r == 0) ? $urandom() : (r == 1) ? 32'(1024 + $urandom_range(0, 15))
                                               : 32'($urandom_range(0, 1023));
      size  = 2'($urandom_range(0, 3));
      we    = 1'($urandom_range(0, 1));
      uns   = 1'($urandom_range(0, 1));
      wdata = $urandom();
      ref_access(we, size, uns, addr, wdata, erd, eer, el, en, ew);
      run_req(we, size, uns, addr, wdata, rd, er, lat, nwe, wa, wd, tmo);
      n_checks++;
      if (tmo || er !== eer || rd !== erd || lat != el || nwe != en)
        $display("FAIL rand_rsp it=%0d we=%b sz=%0d a=%h: tmo=%b err=%b rd=%h lat=%0d wes=%0d, need err=%b rd=%h lat=%0d wes=%0d",
                 it, we, size, addr, tmo, er, rd, lat, nwe, eer, erd, el, en);
      else n_pass++;
      if (en == 1) begin
        n_checks++;
        if (wa !== (addr >> 2) || wd !== ew)
          $display("FAIL rand_write it=%0d: addr=%h data=%h, need %h %h", it, wa, wd, addr >> 2, ew);
        else n_pass++;
      end
    end
  endtask

  initial begin
    reset = 1'b1; ram_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'b0; req_wdata = 32'b0; rsp_ready = 1'b0;
    for (int i = 0; i < MW; i++)
      for (int b = 0; b < 4; b++) ref_bytes[4 * i + b] = init_word(i)[8 * b +: 8];
    repeat (3) @(posedge clk);
    ram_init = 1'b0;
    test_reset;
    @(negedge clk) reset = 1'b0;
    test_reset;
    test_word_store;
    test_loads;
    test_subword_store;
    test_errors;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
